// File: rtl/echip_clkgen_prog.sv
// echip_clkgen_prog: programmable modulator/filter/serializer clock generator.
// A phase counter p runs 0..N-1. Every output is a registered decode of the
// *next* p, so each output changes on the same edge that loads that p.
// Ratio, gap, sclk phase and frame length live in shadow registers. The shadow
// registers follow the inputs while idle and reload only at period
// boundaries while running.
module echip_clkgen_prog #(
  parameter int CNT_W       = 6,
  parameter int DEC_W       = 8,
  parameter int DIV_DEFAULT = 16,
  parameter int GAP_DEFAULT = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             enable,
  input  logic [CNT_W-1:0] div_ratio,
  input  logic [3:0]       nonoverlap,
  input  logic [CNT_W-1:0] sclk_phase,
  input  logic [DEC_W-1:0] dec_ratio,
  output logic             phi1,
  output logic             phi2,
  output logic             phi1F,
  output logic             sclk,
  output logic             frame_strobe,
  output logic             running
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] N_MIN = CNT_W'(4);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] p, p_nxt;
  logic [DEC_W-1:0] fcnt, f_nxt;

  // Shadow (currently applied) parameters, always held in clamped form.
  logic [CNT_W-1:0] n_sh, g_sh, s_sh;
  logic [DEC_W-1:0] d_sh;

  // Clamped versions of the live inputs.
  logic [CNT_W-1:0] n_in, h_in, g_in, s_in, gap_ext;
  logic [DEC_W-1:0] d_in;

  // Parameters that apply to the cycle being loaded.
  logic             wrap, load;
  logic [CNT_W-1:0] n_nx, h_nx, g_nx, s_nx;
  logic [DEC_W-1:0] d_nx;
  logic [CNT_W:0]   sclk_ofs;
  logic             run_dec;
  logic             phi1_nx, phi2_nx, phi1f_nx, sclk_nx, strobe_nx;

  // The state flop doubles as the running indicator.
  assign running = (state == ST_RUN);

  // Clamp the raw inputs: N >= 4, g <= H-1, S <= N-1, D >= 1.
  always_comb begin
    n_in    = (div_ratio < N_MIN) ? N_MIN : div_ratio;
    h_in    = n_in >> 1;
    gap_ext = CNT_W'(nonoverlap);
    g_in    = (gap_ext > (h_in - CNT_W'(1))) ? (h_in - CNT_W'(1)) : gap_ext;
    s_in    = (sclk_phase > (n_in - CNT_W'(1))) ? (n_in - CNT_W'(1)) : sclk_phase;
    d_in    = (dec_ratio == '0) ? DEC_W'(1) : dec_ratio;
  end

  // Next-state, next phase/frame count and next output decodes.
  always_comb begin
    state_nxt = state;
    p_nxt     = '0;
    f_nxt     = '0;
    run_dec   = 1'b0;

    wrap = (state == ST_RUN) && (p == (n_sh - CNT_W'(1)));
    load = (state == ST_IDLE) || wrap;

    n_nx = load ? n_in : n_sh;
    g_nx = load ? g_in : g_sh;
    s_nx = load ? s_in : s_sh;
    d_nx = load ? d_in : d_sh;
    h_nx = n_nx >> 1;

    case (state)
      ST_IDLE: begin
        if (enable) begin
          state_nxt = ST_RUN;
          run_dec   = 1'b1;
        end
      end
      ST_RUN: begin
        if (wrap) begin
          if (!enable) begin
            // Stop only at a period boundary; counters return to zero.
            state_nxt = ST_IDLE;
          end else begin
            run_dec = 1'b1;
            f_nxt   = (fcnt >= (d_nx - DEC_W'(1))) ? '0 : (fcnt + DEC_W'(1));
          end
        end else begin
          run_dec = 1'b1;
          p_nxt   = p + CNT_W'(1);
          f_nxt   = fcnt;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Distance of p behind the sclk rising point, modulo N.
    if (p_nxt >= s_nx) sclk_ofs = {1'b0, p_nxt} - {1'b0, s_nx};
    else               sclk_ofs = {1'b0, p_nxt} + {1'b0, n_nx} - {1'b0, s_nx};

    phi1_nx   = run_dec && (p_nxt < (h_nx - g_nx));
    phi2_nx   = run_dec && (p_nxt >= h_nx) && (p_nxt < (n_nx - g_nx));
    phi1f_nx  = run_dec && (p_nxt < h_nx);
    sclk_nx   = run_dec && (sclk_ofs < {1'b0, h_nx});
    strobe_nx = run_dec && (p_nxt == '0) && (f_nxt == '0);
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Shadow parameters: follow inputs while idle, reload only on wrap while running.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      n_sh <= CNT_W'(DIV_DEFAULT);
      g_sh <= CNT_W'(GAP_DEFAULT);
      s_sh <= '0;
      d_sh <= DEC_W'(1);
    end else if (load) begin
      n_sh <= n_in;
      g_sh <= g_in;
      s_sh <= s_in;
      d_sh <= d_in;
    end
  end

  // Phase/frame counters and registered clock outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      p            <= '0;
      fcnt         <= '0;
      phi1         <= 1'b0;
      phi2         <= 1'b0;
      phi1F        <= 1'b0;
      sclk         <= 1'b0;
      frame_strobe <= 1'b0;
    end else begin
      p            <= p_nxt;
      fcnt         <= f_nxt;
      phi1         <= phi1_nx;
      phi2         <= phi2_nx;
      phi1F        <= phi1f_nx;
      sclk         <= sclk_nx;
      frame_strobe <= strobe_nx;
    end
  end

endmodule

// File: tb/tb_echip_clkgen_prog.sv
// Directed testbench for echip_clkgen_prog. Outputs are sampled 1 ns after
// each rising clk edge. Expected waveforms per period are hand-computed
// bitmasks indexed by phase p.
module tb_echip_clkgen_prog;

  logic       clk = 1'b0;
  logic       rstn;
  logic       enable;
  logic [5:0] div_ratio;
  logic [3:0] nonoverlap;
  logic [5:0] sclk_phase;
  logic [7:0] dec_ratio;
  logic       phi1, phi2, phi1F, sclk, frame_strobe, running;

  int checks = 0;
  int errors = 0;

  // N=16, g=1, S=4
  localparam logic [63:0] A_P1 = 64'h0000_007F;
  localparam logic [63:0] A_P2 = 64'h0000_7F00;
  localparam logic [63:0] A_PF = 64'h0000_00FF;
  localparam logic [63:0] A_SC = 64'h0000_0FF0;
  // N=17, g=2, S=4
  localparam logic [63:0] B_P1 = 64'h0000_003F;
  localparam logic [63:0] B_P2 = 64'h0000_7F00;
  localparam logic [63:0] B_PF = 64'h0000_00FF;
  localparam logic [63:0] B_SC = 64'h0000_0FF0;
  // N=16, g clamped to 7, S=4
  localparam logic [63:0] C_P1 = 64'h0000_0001;
  localparam logic [63:0] C_P2 = 64'h0000_0100;
  // N=4 (from div_ratio=2), g clamped to 1, S clamped to 3
  localparam logic [63:0] D_P1 = 64'h1;
  localparam logic [63:0] D_P2 = 64'h4;
  localparam logic [63:0] D_PF = 64'h3;
  localparam logic [63:0] D_SC = 64'h9;
  // N=32, g=1, S=4
  localparam logic [63:0] E_P1 = 64'h0000_0000_0000_7FFF;
  localparam logic [63:0] E_P2 = 64'h0000_0000_7FFF_0000;
  localparam logic [63:0] E_PF = 64'h0000_0000_0000_FFFF;
  localparam logic [63:0] E_SC = 64'h0000_0000_000F_FFF0;

  echip_clkgen_prog dut (
    .clk         (clk),
    .rstn        (rstn),
    .enable      (enable),
    .div_ratio   (div_ratio),
    .nonoverlap  (nonoverlap),
    .sclk_phase  (sclk_phase),
    .dec_ratio   (dec_ratio),
    .phi1        (phi1),
    .phi2        (phi2),
    .phi1F       (phi1F),
    .sclk        (sclk),
    .frame_strobe(frame_strobe),
    .running     (running)
  );

  // Clock: 10 ns period.
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, " phi1"}, phi1, 0);
    check({tag, " phi2"}, phi2, 0);
    check({tag, " phi1F"}, phi1F, 0);
    check({tag, " sclk"}, sclk, 0);
    check({tag, " strobe"}, frame_strobe, 0);
    check({tag, " running"}, running, 0);
  endtask

  // Check phases lo..hi-1 of one period, advancing one clk per phase.
  task automatic span(input string tag, input int lo, input int hi,
                      input logic [63:0] m1, input logic [63:0] m2,
                      input logic [63:0] mf, input logic [63:0] ms, input logic st0);
    for (int i = lo; i < hi; i++) begin
      check($sformatf("%s p%0d phi1", tag, i), phi1, m1[i]);
      check($sformatf("%s p%0d phi2", tag, i), phi2, m2[i]);
      check($sformatf("%s p%0d phi1F", tag, i), phi1F, mf[i]);
      check($sformatf("%s p%0d sclk", tag, i), sclk, ms[i]);
      check($sformatf("%s p%0d strobe", tag, i), frame_strobe, (i == 0) && st0);
      check($sformatf("%s p%0d running", tag, i), running, 1);
      check($sformatf("%s p%0d overlap", tag, i), phi1 & phi2, 0);
      tick();
    end
  endtask

  initial begin
    // Reset asserted asynchronously before any clock edge.
    rstn       = 1'b1;
    enable     = 1'b0;
    div_ratio  = 6'd16;
    nonoverlap = 4'd1;
    sclk_phase = 6'd4;
    dec_ratio  = 8'd4;
    #1 rstn = 1'b0;
    #1 check_idle("reset_async");
    repeat (3) tick();
    check_idle("reset_held");
    rstn = 1'b1;
    tick();
    check_idle("idle_no_enable");

    // Defaults N=16 g=1 S=4 D=4: strobe every 4 periods (64 clks).
    enable = 1'b1;
    tick();
    span("def0", 0, 16, A_P1, A_P2, A_PF, A_SC, 1);
    span("def1", 0, 16, A_P1, A_P2, A_PF, A_SC, 0);
    span("def2", 0, 16, A_P1, A_P2, A_PF, A_SC, 0);
    span("def3", 0, 16, A_P1, A_P2, A_PF, A_SC, 0);
    span("def4", 0, 16, A_P1, A_P2, A_PF, A_SC, 1);

    // N=17 g=2 D=1 programmed at p=0; current period keeps old settings.
    div_ratio  = 6'd17;
    nonoverlap = 4'd2;
    dec_ratio  = 8'd1;
    span("def5", 0, 16, A_P1, A_P2, A_PF, A_SC, 0);
    span("n17a", 0, 17, B_P1, B_P2, B_PF, B_SC, 1);
    div_ratio  = 6'd16;
    nonoverlap = 4'd15;
    span("n17b", 0, 17, B_P1, B_P2, B_PF, B_SC, 1);

    // Gap clamp: nonoverlap=15 with N=16 gives g=7.
    div_ratio = 6'd2;
    dec_ratio = 8'd0;
    span("gclamp", 0, 16, C_P1, C_P2, A_PF, A_SC, 1);

    // div_ratio=2 -> N=4, dec_ratio=0 -> strobe every period.
    span("n4a", 0, 4, D_P1, D_P2, D_PF, D_SC, 1);
    span("n4b", 0, 4, D_P1, D_P2, D_PF, D_SC, 1);
    div_ratio  = 6'd16;
    nonoverlap = 4'd1;
    dec_ratio  = 8'd1;
    span("n4c", 0, 4, D_P1, D_P2, D_PF, D_SC, 1);

    // Mid-period change to 32 at p=5 only affects the following period.
    span("mid16a", 0, 5, A_P1, A_P2, A_PF, A_SC, 1);
    div_ratio = 6'd32;
    span("mid16b", 5, 16, A_P1, A_P2, A_PF, A_SC, 1);
    div_ratio = 6'd16;
    span("n32", 0, 32, E_P1, E_P2, E_PF, E_SC, 1);

    // Stop: enable dropped at p=3 takes effect on the wrap edge.
    span("stopa", 0, 3, A_P1, A_P2, A_PF, A_SC, 1);
    enable = 1'b0;
    span("stopb", 3, 16, A_P1, A_P2, A_PF, A_SC, 1);
    check_idle("stopped");
    tick();
    check_idle("stopped2");

    // Restart: next edge gives phi1=phi1F=strobe=1.
    enable = 1'b1;
    tick();
    span("restart", 0, 16, A_P1, A_P2, A_PF, A_SC, 1);

    // Two-clk enable glitch inside a period does not stop the generator.
    span("glitcha", 0, 4, A_P1, A_P2, A_PF, A_SC, 1);
    enable = 1'b0;
    span("glitchb", 4, 6, A_P1, A_P2, A_PF, A_SC, 1);
    enable = 1'b1;
    span("glitchc", 6, 16, A_P1, A_P2, A_PF, A_SC, 1);
    span("glitchd", 0, 16, A_P1, A_P2, A_PF, A_SC, 1);

    // Reset mid-run at p=9, between clk edges.
    dec_ratio = 8'd4;
    span("prerst", 0, 9, A_P1, A_P2, A_PF, A_SC, 1);
    #2 rstn = 1'b0;
    #1 check_idle("rst_mid_async");
    tick();
    tick();
    check_idle("rst_mid_held");
    rstn = 1'b1;
    tick();
    span("post0", 0, 16, A_P1, A_P2, A_PF, A_SC, 1);
    span("post1", 0, 16, A_P1, A_P2, A_PF, A_SC, 0);
    span("post2", 0, 16, A_P1, A_P2, A_PF, A_SC, 0);
    span("post3", 0, 16, A_P1, A_P2, A_PF, A_SC, 0);
    span("post4", 0, 16, A_P1, A_P2, A_PF, A_SC, 1);

    enable = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
